// File: rtl/expr_pipe_pkg.sv
// Shared constants and types for the expr_pipe_join streaming arithmetic block.
package expr_pipe_pkg;

    localparam int unsigned LAT       = 3;
    localparam int unsigned K_C_DEF   = 3;
    localparam int unsigned K_D_DEF   = 4;
    localparam int unsigned SHIFT_DEF = 1;

    // One valid bit per pipeline stage: [0]=S1, [1]=S2, [2]=S3 (output)
    typedef logic [LAT-1:0] stage_vld_t;

endpackage

// File: rtl/expr_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
module expr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             artsn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;

    always_comb begin
        wr_nxt = wr_ptr + PW'(push);
        rd_nxt = rd_ptr + PW'(pop);
    end

    // Flags are computed from next pointers so they are valid right after the edge
    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/expr_pipe_join.sv
// Four-stream join feeding a 3-stage pipeline: q = ((a-b)*(1+K_C*c) - K_D*d) >> SHIFT.
// Optional result counter output res_cnt_o enabled by defining EXPR_PIPE_CNT_EN.
module expr_pipe_join
    import expr_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned K_C        = K_C_DEF,
    parameter int unsigned K_D        = K_D_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF
) (
    input  logic                  clk_i,
    input  logic                  artsn_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  a_valid_i,
    input  logic                  b_valid_i,
    input  logic                  c_valid_i,
    input  logic                  d_valid_i,
    output logic                  a_ready_o,
    output logic                  b_ready_o,
    output logic                  c_ready_o,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  q_valid_o,
    input  logic                  q_ready_i
`ifdef EXPR_PIPE_CNT_EN
    ,
    output logic [31:0]           res_cnt_o
`endif
);

    localparam int unsigned W = DATA_WIDTH;
    localparam logic [W-1:0] KC = W'(K_C);
    localparam logic [W-1:0] KD = W'(K_D);

    logic [3:0][W-1:0] wr_data;
    logic [3:0][W-1:0] rd_data;
    logic [3:0]        in_valid;
    logic [3:0]        push;
    logic [3:0]        full;
    logic [3:0]        empty;
    logic              en;
    logic              fire;
    stage_vld_t        vld;
    logic [W-1:0]      diff_s1;
    logic [W-1:0]      m_s1;
    logic [W-1:0]      dk_s1;
    logic [W-1:0]      p_s2;
    logic [W-1:0]      dk_s2;

    assign wr_data  = {d_i, c_i, b_i, a_i};
    assign in_valid = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};

    // Ready depends only on registered full flags; forced low while in reset
    assign a_ready_o = artsn_i & ~full[0];
    assign b_ready_o = artsn_i & ~full[1];
    assign c_ready_o = artsn_i & ~full[2];
    assign d_ready_o = artsn_i & ~full[3];

    assign en   = !(q_valid_o && !q_ready_i);
    assign fire = (&(~empty)) && en;

    for (genvar i = 0; i < 4; i++) begin : g_fifo
        assign push[i] = in_valid[i] & ~full[i];

        expr_fifo #(
            .WIDTH (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .artsn_i (artsn_i),
            .push    (push[i]),
            .wr_data (wr_data[i]),
            .pop     (fire),
            .rd_data (rd_data[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // Stage valids and result register; q_o only reloads on a real result
    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            vld <= '0;
            q_o <= '0;
        end else if (en) begin
            vld <= {vld[LAT-2:0], fire};
            if (vld[1]) begin
                q_o <= (p_s2 - dk_s2) >> SHIFT;
            end
        end
    end

    // Datapath registers carry no reset; their validity is tracked by vld
    always_ff @(posedge clk_i) begin
        if (en) begin
            diff_s1 <= rd_data[0] - rd_data[1];
            m_s1    <= W'(1) + W'(KC * rd_data[2]);
            dk_s1   <= W'(KD * rd_data[3]);
            p_s2    <= W'(diff_s1 * m_s1);
            dk_s2   <= dk_s1;
        end
    end

    assign q_valid_o = vld[LAT-1];

`ifdef EXPR_PIPE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            res_cnt_o <= '0;
        end else if (q_valid_o && q_ready_i) begin
            res_cnt_o <= res_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_expr_pipe_join.sv
// Directed self-checking bench for expr_pipe_join (default parameters).
module tb_expr_pipe_join;

    logic        clk_i;
    logic        artsn_i;
    logic [31:0] a_i, b_i, c_i, d_i;
    logic        a_valid_i, b_valid_i, c_valid_i, d_valid_i;
    logic        a_ready_o, b_ready_o, c_ready_o, d_ready_o;
    logic [31:0] q_o;
    logic        q_valid_o;
    logic        q_ready_i;
`ifdef EXPR_PIPE_CNT_EN
    logic [31:0] res_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int acc;
    logic rdy;

    expr_pipe_join dut (
        .clk_i     (clk_i),
        .artsn_i   (artsn_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .c_i       (c_i),
        .d_i       (d_i),
        .a_valid_i (a_valid_i),
        .b_valid_i (b_valid_i),
        .c_valid_i (c_valid_i),
        .d_valid_i (d_valid_i),
        .a_ready_o (a_ready_o),
        .b_ready_o (b_ready_o),
        .c_ready_o (c_ready_o),
        .d_ready_o (d_ready_o),
        .q_o       (q_o),
        .q_valid_o (q_valid_o),
        .q_ready_i (q_ready_i)
`ifdef EXPR_PIPE_CNT_EN
        ,
        .res_cnt_o (res_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // v = {d,c,b,a} valids
    task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        {d_valid_i, c_valid_i, b_valid_i, a_valid_i} = v;
        a_i = a;
        b_i = b;
        c_i = c;
        d_i = d;
    endtask

    initial begin
        artsn_i   = 1'b0;
        q_ready_i = 1'b1;
        drive(4'h0, 0, 0, 0, 0);
        #1;
        chk("rst_a_ready", 32'(a_ready_o), 0);
        chk("rst_d_ready", 32'(d_ready_o), 0);
        tick();
        tick();
        chk("rst_q_valid", 32'(q_valid_o), 0);
        chk("rst_q", q_o, 0);
        chk("rst_b_ready", 32'(b_ready_o), 0);
        artsn_i = 1'b1;
        tick();
        chk("rel_a_ready", 32'(a_ready_o), 1);
        chk("rel_c_ready", 32'(c_ready_o), 1);
`ifdef EXPR_PIPE_CNT_EN
        chk("cnt_rst", res_cnt_o, 0);
`endif

        // Basic: (10-4)*(1+6) - 4 = 38, >>1 = 19, valid after E+3
        drive(4'hF, 10, 4, 2, 1);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        chk("basic_e0", 32'(q_valid_o), 0);
        tick();
        chk("basic_e1", 32'(q_valid_o), 0);
        tick();
        chk("basic_e2", 32'(q_valid_o), 0);
        tick();
        chk("basic_e3_valid", 32'(q_valid_o), 1);
        chk("basic_e3_q", q_o, 19);
        tick();
        chk("basic_e4_valid", 32'(q_valid_o), 0);

        // Wrap-around, two back-to-back sets
        drive(4'hF, 0, 1, 0, 0);
        tick();
        drive(4'hF, 0, 0, 0, 1);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        tick();
        chk("wrap1_valid", 32'(q_valid_o), 1);
        chk("wrap1_q", q_o, 32'h7FFF_FFFF);
        tick();
        chk("wrap2_valid", 32'(q_valid_o), 1);
        chk("wrap2_q", q_o, 32'h7FFF_FFFE);
        tick();
        chk("wrap_idle", 32'(q_valid_o), 0);

        // Staggered arrival: a@0 (and a second a@1), b@2, c@5, d@7
        drive(4'b0001, 10, 0, 0, 0);
        tick();
        drive(4'b0001, 99, 0, 0, 0);
        tick();
        drive(4'b0010, 0, 4, 0, 0);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        tick();
        drive(4'b0100, 0, 0, 2, 0);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        drive(4'b1000, 0, 0, 0, 1);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        chk("stag_e8", 32'(q_valid_o), 0);
        tick();
        chk("stag_e9", 32'(q_valid_o), 0);
        tick();
        chk("stag_e10_valid", 32'(q_valid_o), 1);
        chk("stag_e10_q", q_o, 19);
        // Buffered second a = 99 joins with b=c=d=0: 99 >> 1 = 49
        drive(4'b1110, 0, 0, 0, 0);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("stag2_valid", 32'(q_valid_o), 1);
        chk("stag2_q", q_o, 49);
        tick();

        // Backpressure: set k = (2k+20, 0, 1, 1) -> q = 4k+38
        q_ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(4'hF, 32'(2 * acc + 20), 0, 1, 1);
            rdy = a_ready_o;
            tick();
            if (rdy) acc++;
        end
        drive(4'h0, 0, 0, 0, 0);
        chk("bp_accepted", 32'(acc), 7);
        chk("bp_a_ready", 32'(a_ready_o), 0);
        chk("bp_b_ready", 32'(b_ready_o), 0);
        chk("bp_c_ready", 32'(c_ready_o), 0);
        chk("bp_d_ready", 32'(d_ready_o), 0);
        chk("bp_hold_valid", 32'(q_valid_o), 1);
        chk("bp_hold_q0", q_o, 38);
        tick();
        tick();
        chk("bp_hold_q1", q_o, 38);
        q_ready_i = 1'b1;
        for (int k = 1; k < 7; k++) begin
            tick();
            chk("bp_drain_valid", 32'(q_valid_o), 1);
            chk("bp_drain_q", q_o, 32'(4 * k + 38));
        end
        tick();
        chk("bp_drain_end", 32'(q_valid_o), 0);
        chk("bp_ready_back", 32'(a_ready_o), 1);

        // Reset mid-operation with buffered and in-flight sets
        q_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 32'(i + 1), 0, 0, 0);
            tick();
        end
        drive(4'h0, 0, 0, 0, 0);
        chk("mid_pre_valid", 32'(q_valid_o), 1);
        artsn_i = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(b_ready_o), 0);
        tick();
        chk("mid_rst_valid", 32'(q_valid_o), 0);
        chk("mid_rst_q", q_o, 0);
        artsn_i = 1'b1;
        q_ready_i = 1'b1;
        tick();
        chk("mid_rel_ready", 32'(a_ready_o), 1);
`ifdef EXPR_PIPE_CNT_EN
        chk("cnt_after_rst", res_cnt_o, 0);
`endif
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_stale", 32'(q_valid_o), 0);
            tick();
        end

        // Fresh set after reset, then four more for the counter
        drive(4'hF, 10, 4, 2, 1);
        tick();
        drive(4'h0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("post_rst_valid", 32'(q_valid_o), 1);
        chk("post_rst_q", q_o, 19);
        for (int i = 0; i < 4; i++) begin
            drive(4'hF, 10, 4, 2, 1);
            tick();
        end
        drive(4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("final_idle", 32'(q_valid_o), 0);
`ifdef EXPR_PIPE_CNT_EN
        chk("cnt_five", res_cnt_o, 5);
        artsn_i = 1'b0;
        tick();
        chk("cnt_reset", res_cnt_o, 0);
        artsn_i = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_pipe_join.md
# expr_pipe_join

Streaming, parametrised successor to the fixed-function `top` arithmetic unit. It computes q = ((a − b)·(1 + K_C·c) − K_D·d) >> SHIFT over four independent operand streams. Each stream has its own valid/ready handshake and an in-order buffer, so operands may arrive on different cycles and are still matched in order. The output has valid/ready backpressure, and the block sits between operand producers and a downstream result consumer.

## Interface
- DATA_WIDTH, 32: width of operands, intermediates and result
- FIFO_DEPTH, 4: entries per operand buffer; power of two, ≥ 2
- K_C, 3: coefficient applied to c
- K_D, 4: coefficient applied to d
- SHIFT, 1: final logical right-shift amount, 0 ≤ SHIFT < DATA_WIDTH
- clk_i  in  1  clock; all state changes on the rising edge
- artsn_i  in  1  reset, synchronous and active-low
- a_i / b_i / c_i / d_i  in  DATA_WIDTH  operand data
- a_valid_i / b_valid_i / c_valid_i / d_valid_i  in  1  operand valid
- a_ready_o / b_ready_o / c_ready_o / d_ready_o  out  1  operand ready (buffer not full)
- q_o  out  DATA_WIDTH  result
- q_valid_o  out  1  result valid
- q_ready_i  in  1  consumer accepts result

## Operation
- Operand push: an operand is pushed on a rising edge where x_valid_i && x_ready_o.
- Ready: x_ready_o = !full. It is registered-state based, with no combinational path from q_ready_i or any pop. A push to a full buffer is not accepted, even if a pop happens in the same cycle.
- Join: fire = all four buffers non-empty && en. On fire, one entry is popped from every buffer, and those entries enter S1 together.
- Pipeline enable: en = !(q_valid_o && !q_ready_i). This is a global stall; S1–S3 hold when en = 0, and bubbles do not collapse.
- S1 registers diff = a − b, m = 1 + K_C·c and dk = K_D·d.
- S2 registers p = diff·m.
- S3 (the output register) loads q_o = (p − dk) >> SHIFT.
- Each stage carries a valid bit. q_valid_o is the S3 valid bit.
- Arithmetic:
  - All operations are unsigned and modulo 2^DATA_WIDTH; every product is truncated to its low DATA_WIDTH bits.
  - The shift is logical (zero-fill). This is identical to unsigned integer division by 2^SHIFT of the truncated value.
- Ordering: results leave strictly in operand-set order. No set is dropped or duplicated.
- Reset (artsn_i low at an edge):
  - All buffers are emptied and all stage valid bits are cleared; q_o is set to 0.
  - While artsn_i is low, every x_ready_o is forced to 0.
  - Reset mid-operation discards all buffered and in-flight data.

## Timing
- Reset values: q_o = 0, q_valid_o = 0, x_ready_o = 0 during reset, and 1 on the first cycle after release.
- Latency: if the last operand of a set is pushed at edge E with no stall, q_valid_o is high after edge E+3.
- Throughput: one result per cycle when all streams are valid every cycle and q_ready_i = 1.
- Handshake: q_o and q_valid_o are held stable while q_valid_o && !q_ready_i.
- Capacity while stalled: FIFO_DEPTH sets in the buffers plus 3 in the pipeline.
- Simultaneous push and pop on a non-full buffer: both take effect, and occupancy is unchanged.

## Configuration
- EXPR_PIPE_CNT_EN defined:
  - Adds output res_cnt_o [31:0], reset to 0.
  - It increments on every q_valid_o && q_ready_i and wraps from 0xFFFFFFFF to 0.
- EXPR_PIPE_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package expr_pipe_pkg holds:
  - the latency constant LAT = 3;
  - the stage-valid vector typedef;
  - the default coefficient constants K_C_DEF = 3, K_D_DEF = 4, SHIFT_DEF = 1.
- Sub-module expr_fifo: synchronous FIFO parametrised by width and depth, with a full/empty flag and pointers that wrap at FIFO_DEPTH. It is instantiated four times.

## Test plan
- Basic: a=10, b=4, c=2, d=1, all valid in one cycle, q_ready_i=1 → q_o = 19 with q_valid_o for one cycle, exactly 3 edges after the push.
- Wrap-around: a=0, b=1, c=0, d=0 → q_o = 0x7FFFFFFF. Then a=0, b=0, c=0, d=1 → q_o = 0x7FFFFFFE.
- Staggered arrival: a pushed at edge 0, b at 2, c at 5, d at 7 with values 10/4/2/1 → q_valid_o first high after edge 10 with q_o = 19. Meanwhile a second a, pushed at edge 1, stays buffered.
- Backpressure: q_ready_i held 0 while pushing sets continuously (FIFO_DEPTH=4) → exactly 7 sets accepted, after which all x_ready_o = 0. Raising q_ready_i then drains 7 results in order, and q_o is held stable during the stall.
- Reset mid-operation: artsn_i low for one edge with 2 buffered sets and 2 in flight → next cycle q_valid_o = 0 and q_o = 0. No stale result appears afterwards, and ready returns to 1 on the first cycle after release.
- Counter (EXPR_PIPE_CNT_EN): 5 accepted results → res_cnt_o = 5; reset → 0.
